// File: rtl/dsn_lif_array.sv
// dsn_lif_array: time-multiplexed leaky integrate-and-fire neuron array.
// Define DSN_REFRACTORY_EN to build the per-neuron refractory counters.
module dsn_lif_array #(
    parameter int N_NEURONS = 4,
    parameter int VW        = 13,
    parameter int IW        = 8,
    parameter int CW        = 8,
    localparam int IDW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IDW-1:0] in_id,
    input  logic [IW-1:0]  in_vpre,
    input  logic [IW-1:0]  leak,
    input  logic [VW-1:0]  vth,
    input  logic [CW-1:0]  refrac,
    output logic           spike_valid,
    output logic [IDW-1:0] spike_id,
    output logic [VW-1:0]  spike_vfire,
    output logic [CW-1:0]  spike_count,
    output logic           evt_drop,
    output logic           id_err
);

    typedef enum logic [1:0] {
        IDLE,
        LEAK,
        INTEG,
        CMP
    } state_t;

    state_t state, state_n;

    logic           accept;
    logic           wb;
    logic           fire;
    logic           id_ok;
    logic           ref_busy;
    logic [2**IDW-1:0] id_map;

    logic [IDW-1:0] id_q;
    logic [IW-1:0]  vpre_q;
    logic [IW-1:0]  leak_q;
    logic [VW-1:0]  vth_q;
    logic [VW-1:0]  acc_q;
    logic           bad_q;

    logic [VW-1:0]  mem [N_NEURONS];
    logic [CW-1:0]  ivl [N_NEURONS];

    logic [VW-1:0]  mem_rd;
    logic [VW-1:0]  leak_ext;
    logic [VW-1:0]  v1;
    logic [VW-1:0]  v2;
    logic [VW:0]    sum;

`ifdef DSN_REFRACTORY_EN
    logic           drop;
    logic [CW-1:0]  refrac_q;
    logic [CW-1:0]  ref_cnt [N_NEURONS];
`else
    logic           unused_refrac;
`endif

    assign in_ready = (state == IDLE);

    // Map every encodable id to whether a neuron exists behind it
    always_comb begin
        id_map = '0;
        for (int i = 0; i < 2**IDW; i++) begin
            id_map[i] = (i < N_NEURONS);
        end
    end

    assign id_ok = id_map[in_id];

`ifdef DSN_REFRACTORY_EN
    assign ref_busy = (ref_cnt[id_q] != '0);
`else
    assign ref_busy      = 1'b0;
    assign unused_refrac = ^refrac;
    assign evt_drop      = 1'b0;
`endif

    // Event sequencer state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle strobes for the event sequencer
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        wb      = 1'b0;
        fire    = 1'b0;
`ifdef DSN_REFRACTORY_EN
        drop    = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_n = LEAK;
                end
            end
            LEAK: begin
                if (bad_q) begin
                    state_n = IDLE;
                end else if (ref_busy) begin
`ifdef DSN_REFRACTORY_EN
                    drop    = 1'b1;
`endif
                    state_n = IDLE;
                end else begin
                    state_n = INTEG;
                end
            end
            INTEG: begin
                state_n = CMP;
            end
            CMP: begin
                wb      = 1'b1;
                fire    = (acc_q >= vth_q);
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Saturating leak (floor 0) and integrate (ceiling all-ones)
    always_comb begin
        mem_rd   = mem[id_q];
        leak_ext = VW'(leak_q);
        v1       = (mem_rd > leak_ext) ? (mem_rd - leak_ext) : '0;
        sum      = {1'b0, acc_q} + (VW+1)'(vpre_q);
        v2       = sum[VW] ? '1 : sum[VW-1:0];
    end

    // Latch the event and its run-time parameters at accept
    always_ff @(posedge clock) begin
        if (reset) begin
            id_q     <= '0;
            vpre_q   <= '0;
            leak_q   <= '0;
            vth_q    <= '0;
            bad_q    <= 1'b0;
`ifdef DSN_REFRACTORY_EN
            refrac_q <= '0;
`endif
        end else if (accept) begin
            id_q     <= in_id;
            vpre_q   <= in_vpre;
            leak_q   <= leak;
            vth_q    <= vth;
            bad_q    <= !id_ok;
`ifdef DSN_REFRACTORY_EN
            refrac_q <= refrac;
`endif
        end
    end

    // Working membrane value: v1 after LEAK, v2 after INTEG
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else if (state == LEAK) begin
            acc_q <= v1;
        end else if (state == INTEG) begin
            acc_q <= v2;
        end
    end

    // Sticky flag for events aimed past the last neuron
    always_ff @(posedge clock) begin
        if (reset) begin
            id_err <= 1'b0;
        end else if (accept && !id_ok) begin
            id_err <= 1'b1;
        end
    end

    // One-cycle spike record, zeroed whenever no spike is issued
    always_ff @(posedge clock) begin
        if (reset) begin
            spike_valid <= 1'b0;
            spike_id    <= '0;
            spike_vfire <= '0;
            spike_count <= '0;
        end else begin
            spike_valid <= fire;
            spike_id    <= fire ? id_q : '0;
            spike_vfire <= fire ? acc_q : '0;
            spike_count <= fire ? ivl[id_q] : '0;
        end
    end

`ifdef DSN_REFRACTORY_EN
    // Drop pulse for events that hit a refractory neuron
    always_ff @(posedge clock) begin
        if (reset) begin
            evt_drop <= 1'b0;
        end else begin
            evt_drop <= drop;
        end
    end
`endif

    // Membrane writeback: cleared on fire, else holds v2
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                mem[i] <= '0;
            end
        end else if (wb) begin
            mem[id_q] <= fire ? '0 : acc_q;
        end
    end

    // Inter-spike interval: free-running saturating count, cleared on fire
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_NEURONS; i++) begin
            if (reset) begin
                ivl[i] <= '0;
            end else if (fire && (id_q == IDW'(i))) begin
                ivl[i] <= '0;
            end else if (ivl[i] != '1) begin
                ivl[i] <= ivl[i] + 1'b1;
            end
        end
    end

`ifdef DSN_REFRACTORY_EN
    // Refractory countdown, reloaded when the neuron fires
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_NEURONS; i++) begin
            if (reset) begin
                ref_cnt[i] <= '0;
            end else if (fire && (id_q == IDW'(i))) begin
                ref_cnt[i] <= refrac_q;
            end else if (ref_cnt[i] != '0) begin
                ref_cnt[i] <= ref_cnt[i] - 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dsn_lif_array.sv
// tb_dsn_lif_array: directed stimulus, behavioural neuron model, per-cycle compare.
// Five neurons so that a 3-bit id can address a non-existent neuron (5..7).
module tb_dsn_lif_array;

    localparam int NN   = 5;
    localparam int VW   = 13;
    localparam int IW   = 8;
    localparam int CW   = 8;
    localparam int IDW  = 3;
    localparam int VMAX = 8191;
    localparam int CMAX = 255;
    localparam int INF  = 1 << 30;

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [IDW-1:0] in_id;
    logic [IW-1:0]  in_vpre;
    logic [IW-1:0]  leak;
    logic [VW-1:0]  vth;
    logic [CW-1:0]  refrac;
    logic           spike_valid;
    logic [IDW-1:0] spike_id;
    logic [VW-1:0]  spike_vfire;
    logic [CW-1:0]  spike_count;
    logic           evt_drop;
    logic           id_err;

    dsn_lif_array #(
        .N_NEURONS(NN),
        .VW(VW),
        .IW(IW),
        .CW(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_id(in_id),
        .in_vpre(in_vpre),
        .leak(leak),
        .vth(vth),
        .refrac(refrac),
        .spike_valid(spike_valid),
        .spike_id(spike_id),
        .spike_vfire(spike_vfire),
        .spike_count(spike_count),
        .evt_drop(evt_drop),
        .id_err(id_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int edge_n = 0;
    always @(posedge clock) edge_n <= edge_n + 1;

    typedef struct {
        int id;
        int vf;
        int cnt;
    } spk_t;

    int   mem_m [NN];
    int   last_clr [NN];
    bit   fired [NN];
    int   fire_edge [NN];
    int   fire_ref [NN];
    spk_t exp_spk [int];
    bit   exp_drop [int];
    int   acc_edge = INF;
    int   ready_at = 0;
    int   err_from = INF;
    int   err_until = INF;
    bit   chk_on = 0;

    int n_pass = 0;
    int n_chk = 0;
    int spk_cnt = 0;
    int drop_cnt = 0;
    int last_id = -1;
    int last_vf = -1;
    int last_cnt = -1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at edge %0d",
                      nm, act, exp, edge_n);
    endtask

    // Behavioural model: outcome of an event accepted at edge k
    function automatic void model_accept(int k, int id, int vpre,
                                         int lk, int th, int rf);
        int v;
        int c;
        acc_edge = k;
        if (id >= NN) begin
            if (!(err_from <= k && k < err_until)) begin
                err_from = k;
                err_until = INF;
            end
            ready_at = k + 1;
            return;
        end
`ifdef DSN_REFRACTORY_EN
        if (fired[id] && (k - fire_edge[id]) < fire_ref[id]) begin
            exp_drop[k + 1] = 1'b1;
            ready_at = k + 1;
            return;
        end
`endif
        v = mem_m[id] - lk;
        if (v < 0) v = 0;
        v = v + vpre;
        if (v > VMAX) v = VMAX;
        ready_at = k + 3;
        if (v >= th) begin
            c = k + 2 - last_clr[id];
            if (c > CMAX) c = CMAX;
            exp_spk[k + 3] = '{id: id, vf: v, cnt: c};
            mem_m[id] = 0;
            last_clr[id] = k + 3;
            fired[id] = 1'b1;
            fire_edge[id] = k + 3;
            fire_ref[id] = rf;
        end else begin
            mem_m[id] = v;
        end
    endfunction

    // Compare DUT outputs with the model every cycle
    always @(negedge clock) begin : cmp
        int n;
        bit busy;
        if (chk_on) begin
            n = edge_n;
            busy = (n >= acc_edge) && (n < ready_at);
            chk("in_ready", in_ready, !busy);
            if (exp_spk.exists(n)) begin
                chk("spike_valid", spike_valid, 1);
                chk("spike_id", spike_id, exp_spk[n].id);
                chk("spike_vfire", spike_vfire, exp_spk[n].vf);
                chk("spike_count", spike_count, exp_spk[n].cnt);
            end else begin
                chk("spike_valid", spike_valid, 0);
                chk("spike_zero", {spike_id, spike_vfire, spike_count}, 0);
            end
            chk("evt_drop", evt_drop, exp_drop.exists(n));
            chk("id_err", id_err, (n >= err_from) && (n < err_until));
            if (spike_valid === 1'b1) begin
                spk_cnt++;
                last_id = spike_id;
                last_vf = spike_vfire;
                last_cnt = spike_count;
            end
            if (evt_drop === 1'b1) drop_cnt++;
        end
    end

    task automatic do_reset(int hold);
        int r;
        int ks[$];
        r = edge_n + 1;
        foreach (exp_spk[key]) if (key >= r) ks.push_back(key);
        foreach (ks[j]) exp_spk.delete(ks[j]);
        ks.delete();
        foreach (exp_drop[key]) if (key >= r) ks.push_back(key);
        foreach (ks[j]) exp_drop.delete(ks[j]);
        ready_at = r;
        err_until = r;
        for (int i = 0; i < NN; i++) begin
            mem_m[i] = 0;
            fired[i] = 1'b0;
        end
        reset = 1'b1;
        repeat (hold) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NN; i++) last_clr[i] = edge_n;
    endtask

    task automatic send(int id, int vpre, int lk, int th, int rf);
        int g;
        g = 0;
        while (in_ready !== 1'b1 && g < 40) begin
            @(posedge clock);
            #1;
            g++;
        end
        if (g >= 40) chk("ready_timeout", in_ready, 1);
        in_id    = IDW'(id);
        in_vpre  = IW'(vpre);
        leak     = IW'(lk);
        vth      = VW'(th);
        refrac   = CW'(rf);
        in_valid = 1'b1;
        model_accept(edge_n + 1, id, vpre, lk, th, rf);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_id    = IDW'($urandom);
        in_vpre  = IW'($urandom);
        leak     = IW'($urandom);
        vth      = VW'($urandom);
        refrac   = CW'($urandom);
    endtask

    task automatic settle();
        repeat (5) @(posedge clock);
        #1;
    endtask

    task automatic wait_until(int t);
        int g;
        g = 0;
        while (edge_n < t && g < 200) begin
            @(posedge clock);
            #1;
            g++;
        end
    endtask

    task automatic probe(int id);
        send(id, 0, 0, 0, 0);
        settle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        int d0;
        int s;
        in_valid = 1'b0;
        in_id    = '0;
        in_vpre  = '0;
        leak     = '0;
        vth      = '0;
        refrac   = '0;
        do_reset(3);
        chk_on = 1'b1;
        chk("rst_ready", in_ready, 1);
        chk("rst_spike", spike_valid, 0);
        chk("rst_err", id_err, 0);

        // Integrate and fire on neuron 1, neuron 0 left alone
        send(0, 7, 0, 1000, 0);
        c0 = spk_cnt;
        repeat (3) send(1, 100, 0, 300, 0);
        settle();
        chk("t1_nspk", spk_cnt - c0, 1);
        chk("t1_id", last_id, 1);
        chk("t1_vf", last_vf, 300);
        probe(1);
        chk("t1_mem1", last_vf, 0);
        probe(0);
        chk("t1_mem0", last_vf, 7);

        // Leak floor on neuron 2
        send(2, 50, 10, 1000, 0);
        send(2, 50, 10, 1000, 0);
        send(2, 0, 10, 80, 0);
        settle();
        chk("t2_vf80", last_vf, 80);
        send(2, 50, 10, 1000, 0);
        send(2, 50, 10, 1000, 0);
        send(2, 0, 10, 1000, 0);
        repeat (9) send(2, 0, 10, 1000, 0);
        probe(2);
        chk("t2_floor", last_vf, 0);

        // Saturation on neuron 3
        c0 = spk_cnt;
        repeat (33) send(3, 255, 0, 8191, 0);
        settle();
        chk("t3_nspk", spk_cnt - c0, 1);
        chk("t3_id", last_id, 3);
        chk("t3_vf", last_vf, 8191);

        // Refractory window on neuron 0
        send(0, 0, 0, 0, 20);
        s = acc_edge + 3;
        d0 = drop_cnt;
        wait_until(s + 4);
        send(0, 10, 0, 1000, 20);
        wait_until(s + 18);
        send(0, 3, 0, 1000, 20);
        wait_until(s + 24);
        send(0, 5, 0, 1000, 0);
        wait_until(s + 39);
        send(0, 0, 0, 0, 0);
        settle();
        chk("t4_count", last_cnt, 42);
`ifdef DSN_REFRACTORY_EN
        chk("t4_vf", last_vf, 5);
        chk("t4_drops", drop_cnt - d0, 2);
`else
        chk("t4_vf", last_vf, 18);
        chk("t4_drops", drop_cnt - d0, 0);
`endif

        // Refractory expiry edge on neuron 4
        send(4, 0, 0, 0, 3);
        s = acc_edge + 3;
        wait_until(s);
        send(4, 9, 0, 1000, 0);
        send(4, 6, 0, 1000, 0);
        probe(4);
`ifdef DSN_REFRACTORY_EN
        chk("t4b_vf", last_vf, 6);
`else
        chk("t4b_vf", last_vf, 15);
`endif

        // Reset while the event sits in INTEG
        send(1, 40, 0, 1000, 0);
        send(2, 200, 0, 0, 0);
        @(posedge clock);
        #1;
        c0 = spk_cnt;
        do_reset(2);
        chk("t5_ready", in_ready, 1);
        settle();
        chk("t5_nspk", spk_cnt - c0, 0);
        probe(1);
        chk("t5_mem1", last_vf, 0);
        probe(2);
        chk("t5_mem2", last_vf, 0);

        // Out-of-range id
        send(1, 30, 0, 1000, 0);
        c0 = spk_cnt;
        send(5, 200, 0, 0, 0);
        settle();
        chk("t6_err", id_err, 1);
        chk("t6_nspk", spk_cnt - c0, 0);
        probe(1);
        chk("t6_mem1", last_vf, 30);
        chk("t6_sticky", id_err, 1);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
